// File: rtl/pw_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pw_ctrl_pkg : shared state encoding and defaults for pw_req_scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pw_ctrl_pkg;

  localparam int DATA_W_DEFAULT = 128;

  typedef enum logic [2:0] {
    BOOT_WAIT = 3'd0,
    IDLE      = 3'd1,
    ISSUE     = 3'd2,
    BUSY      = 3'd3,
    RESP      = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching upward from ptr+1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  int idx;

  // Walk the offsets from farthest to nearest so the closest requester after ptr wins.
  always_comb begin
    idx    = 0;
    gnt_id = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[ID_W'(idx)]) gnt_id = ID_W'(idx);
    end
    any        = |req;
    gnt_onehot = any ? (N_REQ'(1) << gnt_id) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/pw_req_scheduler.sv
// ---------------------------------------------------------------------------
// pw_req_scheduler : shares one password-encryption wrapper among N_REQ hosts
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pw_req_scheduler
  import pw_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_account,
  input  logic [N_REQ*DATA_W-1:0]   req_password,
  output logic [N_REQ-1:0]          grant,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(N_REQ)-1:0]  resp_id,
  output logic [DATA_W-1:0]         resp_enc,
  output logic                      resp_timeout,
  output logic                      busy,
  input  logic                      boot_done_signal,
  output logic                      go,
  output logic [DATA_W-1:0]         account,
  output logic [DATA_W-1:0]         password,
  input  logic                      done,
  input  logic [DATA_W-1:0]         password_enc
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  acct_q, acct_d;
  logic [DATA_W-1:0]  pwd_q, pwd_d;
  logic [DATA_W-1:0]  enc_q, enc_d;
  logic               tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   arb_onehot;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;
  logic [DATA_W-1:0]  acct_sel, pwd_sel;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  always_comb begin
    acct_sel = '0;
    pwd_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_id == ID_W'(i)) begin
        acct_sel = req_account[i*DATA_W +: DATA_W];
        pwd_sel  = req_password[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    grant_d = grant_q;
    acct_d  = acct_q;
    pwd_d   = pwd_q;
    enc_d   = enc_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT_WAIT: begin
        if (boot_done_signal) state_d = IDLE;
      end
      IDLE: begin
        if (arb_any) begin
          id_d    = arb_id;
          grant_d = arb_onehot;
          acct_d  = acct_sel;
          pwd_d   = pwd_sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // done takes priority over an expiring counter in the same cycle
        if (done) begin
          enc_d   = password_enc;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          enc_d   = '0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          ptr_d   = id_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = BOOT_WAIT;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT_WAIT;
      ptr_q   <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      grant_q <= '0;
      acct_q  <= '0;
      pwd_q   <= '0;
      enc_q   <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      acct_q  <= acct_d;
      pwd_q   <= pwd_d;
      enc_q   <= enc_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign go           = (state_q == ISSUE);
  assign resp_valid   = (state_q == RESP);
  assign grant        = grant_q;
  assign resp_id      = id_q;
  assign resp_enc     = enc_q;
  assign resp_timeout = tmo_q;
  assign busy         = busy_q;
  assign account      = acct_q;
  assign password     = pwd_q;

endmodule

`default_nettype wire
